// File: rtl/peripheral_uart_fifo.sv
// peripheral_uart_fifo: memory-mapped UART with TX/RX FIFOs, a 16x-oversampling
// receiver, sticky error flags and a maskable level interrupt.
// Optional feature: define UART_PARITY_EN to add the CTRL register (b0 parity enable,
// b1 odd parity), a TX parity bit and RX parity checking into PAR_ERR.
module peripheral_uart_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        tx_led,
    output logic        rx_led,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_RXDATA = 4'h2;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CLEAR  = 4'h6;
    localparam logic [3:0] ADDR_DIV    = 4'h8;
    localparam logic [3:0] ADDR_IRQ_EN = 4'hA;
    localparam logic [3:0] ADDR_LEVEL  = 4'hC;
    localparam logic [3:0] ADDR_CTRL   = 4'hE;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
`else
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
`endif

    // Bus decode: a write wins over a simultaneous read, which then has no side effect
    logic wr_en, rd_en;
    assign wr_en = cs & wr;
    assign rd_en = cs & rd & ~wr;

    logic div_wr, irq_en_wr, clr_wr, tx_wr;
    assign div_wr    = wr_en & (addr == ADDR_DIV);
    assign irq_en_wr = wr_en & (addr == ADDR_IRQ_EN);
    assign clr_wr    = wr_en & (addr == ADDR_CLEAR);
    assign tx_wr     = wr_en & (addr == ADDR_TXDATA);

    logic [15:0] div_q;
    logic [2:0]  irq_en_q;
    logic [15:0] tick_cnt;
    logic        tick;

    // Configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= DIV_RESET;
            irq_en_q <= '0;
        end else begin
            if (div_wr)    div_q    <= data_in;
            if (irq_en_wr) irq_en_q <= data_in[2:0];
        end
    end

`ifdef UART_PARITY_EN
    logic [1:0] ctrl_q;
    // Parity control register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
        end else if (wr_en && (addr == ADDR_CTRL)) begin
            ctrl_q <= data_in[1:0];
        end
    end
`endif

    // Oversample tick generator; a divisor write restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (div_wr || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end
    assign tick = (tick_cnt == div_q);

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wptr, tx_rptr;
    logic [CW-1:0]     tx_count;
    logic              tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;
    logic [DATA_W-1:0] tx_head;
    tx_state_e         tx_state;
    logic [3:0]        tx_tcnt, tx_bit;
    logic [DATA_W-1:0] tx_shift;

    assign tx_full    = (tx_count == FULL_CNT);
    assign tx_empty   = (tx_count == '0);
    assign tx_head    = tx_mem[tx_rptr];
    assign tx_pop     = tick & ~tx_empty &
                        ((tx_state == TxIdle) | ((tx_state == TxStop) & (tx_tcnt == 4'd15)));
    assign tx_push    = tx_wr & (~tx_full | tx_pop);
    assign tx_ovf_set = tx_wr & tx_full & ~tx_pop;

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= data_in[DATA_W-1:0];
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
            else if (tx_pop && !tx_push) tx_count <= tx_count - CW'(1);
        end
    end

`ifdef UART_PARITY_EN
    logic tx_par;
`endif

    // TX serializer: one bit per 16 ticks, stop bit chains straight into the next start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TxIdle;
            uart_tx  <= 1'b1;
            tx_led   <= 1'b0;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tick) begin
            unique case (tx_state)
                TxIdle: begin
                    if (!tx_empty) begin
                        tx_state <= TxStart;
                        uart_tx  <= 1'b0;
                        tx_led   <= 1'b1;
                        tx_shift <= tx_head;
                        tx_tcnt  <= '0;
`ifdef UART_PARITY_EN
                        tx_par   <= ^tx_head;
`endif
                    end
                end
                TxStart: begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        tx_state <= TxData;
                        uart_tx  <= tx_shift[0];
                        tx_bit   <= '0;
                    end
                end
                TxData: begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            if (ctrl_q[0]) begin
                                tx_state <= TxParity;
                                uart_tx  <= tx_par ^ ctrl_q[1];
                            end else begin
                                tx_state <= TxStop;
                                uart_tx  <= 1'b1;
                            end
`else
                            tx_state <= TxStop;
                            uart_tx  <= 1'b1;
`endif
                        end else begin
                            tx_bit   <= tx_bit + 4'd1;
                            tx_shift <= tx_shift >> 1;
                            uart_tx  <= tx_shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TxParity: begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        tx_state <= TxStop;
                        uart_tx  <= 1'b1;
                    end
                end
`endif
                TxStop: begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'd15) begin
                        if (!tx_empty) begin
                            tx_state <= TxStart;
                            uart_tx  <= 1'b0;
                            tx_shift <= tx_head;
                            tx_tcnt  <= '0;
`ifdef UART_PARITY_EN
                            tx_par   <= ^tx_head;
`endif
                        end else begin
                            tx_state <= TxIdle;
                            tx_led   <= 1'b0;
                        end
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic rx_s1, rx_s2, rx_prev, rx_fall;

    // Two-flop synchronizer plus one stage for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end
    assign rx_fall = rx_prev & ~rx_s2;

    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wptr, rx_rptr;
    logic [CW-1:0]     rx_count;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    rx_state_e         rx_state;
    logic [3:0]        rx_tcnt, rx_bit;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_stop_hit, rx_ovf_set, frame_set, par_set;

    assign rx_full     = (rx_count == FULL_CNT);
    assign rx_empty    = (rx_count == '0);
    assign rx_pop      = rd_en & (addr == ADDR_RXDATA) & ~rx_empty;
    assign rx_stop_hit = tick & (rx_state == RxStop) & (rx_tcnt == 4'd15);
    assign frame_set   = rx_stop_hit & ~rx_s2;
    assign rx_push     = rx_stop_hit & rx_s2 & (~rx_full | rx_pop);
    assign rx_ovf_set  = rx_stop_hit & rx_s2 & rx_full & ~rx_pop;
`ifdef UART_PARITY_EN
    assign par_set = tick & (rx_state == RxParity) & (rx_tcnt == 4'd15) &
                     (rx_s2 != (^rx_shift ^ ctrl_q[1]));
`else
    assign par_set = 1'b0;
`endif

    // RX deserializer: start confirmed mid-bit, then one sample every 16 ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RxIdle;
            rx_led   <= 1'b0;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            unique case (rx_state)
                RxIdle: begin
                    if (rx_fall) begin
                        rx_state <= RxStart;
                        rx_led   <= 1'b1;
                        rx_tcnt  <= '0;
                    end
                end
                RxStart: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd7) begin
                            rx_tcnt <= '0;
                            rx_bit  <= '0;
                            if (!rx_s2) begin
                                rx_state <= RxData;
                            end else begin
                                // Line went high again: glitch, not a start bit
                                rx_state <= RxIdle;
                                rx_led   <= 1'b0;
                            end
                        end
                    end
                end
                RxData: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
                            rx_bit   <= rx_bit + 4'd1;
                            if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                rx_state <= ctrl_q[0] ? RxParity : RxStop;
`else
                                rx_state <= RxStop;
`endif
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RxParity: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) rx_state <= RxStop;
                    end
                end
`endif
                RxStop: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            rx_state <= RxIdle;
                            rx_led   <= 1'b0;
                        end
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_shift;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
            else if (rx_pop && !rx_push) rx_count <= rx_count - CW'(1);
        end
    end

    // ---------------- Flags, readback, interrupt ----------------
    logic rx_ovf, frame_err, tx_ovf, par_err;

    // Sticky error flags; a set event beats a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
        end else begin
            rx_ovf    <= rx_ovf_set | (rx_ovf    & ~(clr_wr & data_in[5]));
            frame_err <= frame_set  | (frame_err & ~(clr_wr & data_in[6]));
            tx_ovf    <= tx_ovf_set | (tx_ovf    & ~(clr_wr & data_in[7]));
        end
    end

`ifdef UART_PARITY_EN
    // Sticky parity error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_err <= 1'b0;
        else      par_err <= par_set | (par_err & ~(clr_wr & data_in[8]));
    end
`else
    assign par_err = par_set;
`endif

    logic [15:0] ctrl_rd;
`ifdef UART_PARITY_EN
    assign ctrl_rd = {14'd0, ctrl_q};
`else
    assign ctrl_rd = 16'd0;
`endif

    logic [15:0] read_data;

    // Read data mux; unmapped and write-only addresses read as zero
    always_comb begin
        read_data = '0;
        case (addr)
            ADDR_RXDATA: read_data = rx_empty ? 16'd0 : 16'(rx_mem[rx_rptr]);
            ADDR_STATUS: read_data = {7'd0, par_err, tx_ovf, frame_err, rx_ovf, tx_led,
                                      rx_empty, rx_full, tx_empty, tx_full};
            ADDR_DIV:    read_data = div_q;
            ADDR_IRQ_EN: read_data = {13'd0, irq_en_q};
            ADDR_LEVEL:  read_data = {8'(rx_count), 8'(tx_count)};
            ADDR_CTRL:   read_data = ctrl_rd;
            default:     read_data = '0;
        endcase
    end

    // Registered read port, holds between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       data_out <= '0;
        else if (rd_en) data_out <= read_data;
    end

    // Level interrupt from enabled conditions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (irq_en_q[0] & ~rx_empty) |
                   (irq_en_q[1] & tx_empty & ~tx_led) |
                   (irq_en_q[2] & (rx_ovf | frame_err | tx_ovf | par_err));
        end
    end

endmodule

// File: tb/tb_peripheral_uart_fifo.sv
// Self-checking bench for peripheral_uart_fifo: TX frames decoded from uart_tx against a
// scoreboard queue, RX characters checked against a second queue on RXDATA reads.
module tb_peripheral_uart_fifo;

    localparam int DATA_W = 8;

    localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h2, A_ST = 4'h4, A_CLR = 4'h6;
    localparam logic [3:0] A_DIV = 4'h8, A_IEN = 4'hA, A_LVL = 4'hC, A_CTRL = 4'hE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        uart_tx, tx_led, rx_led, irq;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;

    int checks = 0;
    int errors = 0;
    logic [31:0] tx_exp[$];
    logic [31:0] rx_exp[$];

    assign rx_line = loop_en ? uart_tx : rx_drv;

    always #5 clk = ~clk;

    peripheral_uart_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .uart_rx  (rx_line),
        .uart_tx  (uart_tx),
        .tx_led   (tx_led),
        .rx_led   (rx_led),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus tasks are entered on a negedge and return on the next negedge
    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = data_out;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus_read(a, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    // Pops the RX scoreboard and compares against an RXDATA read
    task automatic read_rx(input string tag);
        logic [15:0] v;
        logic [31:0] e;
        bus_read(A_RX, v);
        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 32'hDEAD;
        check(tag, 32'(v), e);
    endtask

    // Drives one frame on uart_rx at DIV=0 (16 clocks per bit)
    task automatic send_rx(input logic [DATA_W-1:0] ch, input logic stop_bit,
                           input bit use_par, input logic par_bit);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < DATA_W; i++) begin
            rx_drv = ch[i];
            repeat (16) @(negedge clk);
            if (i == 0) check("rx_led_busy", 32'(rx_led), 32'd1);
        end
        if (use_par) begin
            rx_drv = par_bit;
            repeat (16) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Decodes frames from uart_tx (DIV=0) and checks them against tx_exp
    initial begin : tx_monitor
        logic [DATA_W-1:0] ch;
        logic [31:0] e;
        int gap;
        bit in_start;
        in_start = 1'b0;
        forever begin
            if (!in_start) begin
                @(negedge clk);
                in_start = (uart_tx === 1'b0) && rst;
            end
            if (in_start) begin
                in_start = 1'b0;
                repeat (8) @(negedge clk);
                check("tx_start_bit", 32'(uart_tx), 32'd0);
                check("tx_led_frame", 32'(tx_led), 32'd1);
                for (int i = 0; i < DATA_W; i++) begin
                    repeat (16) @(negedge clk);
                    ch[i] = uart_tx;
                end
                repeat (16) @(negedge clk);
                check("tx_stop_bit", 32'(uart_tx), 32'd1);
                e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 32'hDEAD;
                check("tx_char", 32'(ch), e);
                if (tx_exp.size() != 0) begin
                    gap = 0;
                    while (uart_tx !== 1'b0 && gap < 40) begin
                        @(negedge clk);
                        gap++;
                    end
                    check("tx_b2b_gap", 32'(gap), 32'd8);
                    in_start = (uart_tx === 1'b0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int len;
        logic [15:0] v;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_leds", 32'({tx_led, rx_led}), 32'd0);
        read_check("rst_status", A_ST, 16'h000A);
        read_check("rst_div", A_DIV, 16'd26);
        read_check("rst_level", A_LVL, 16'h0000);
        read_check("rst_irq_en", A_IEN, 16'h0000);
        read_check("unmapped_read", 4'h1, 16'h0000);

        // Single frame at DIV=0
        bus_write(A_DIV, 16'd0);
        read_check("div_rdback", A_DIV, 16'd0);
        tx_exp.push_back(32'h55);
        bus_write(A_TX, 16'h0055);
        n = 0;
        while (!tx_led && n < 20) begin
            @(negedge clk);
            n++;
        end
        len = 0;
        while (tx_led && len < 400) begin
            @(negedge clk);
            len++;
        end
        check("tx_frame_len", 32'(len), 32'd160);
        check("tx_idle_after", 32'(uart_tx), 32'd1);
        check("tx_sb_drained", 32'(tx_exp.size()), 32'd0);

        // Three back-to-back frames; first char is popped one cycle after its push
        tx_exp.push_back(32'h01);
        tx_exp.push_back(32'h02);
        tx_exp.push_back(32'h03);
        bus_write(A_TX, 16'h0001);
        bus_write(A_TX, 16'h0002);
        bus_write(A_TX, 16'h0003);
        read_check("b2b_level", A_LVL, 16'h0002);
        bus_write(A_IEN, 16'h0002);
        repeat (2) @(negedge clk);
        check("irq_tx_busy", 32'(irq), 32'd0);
        n = 0;
        while (!irq && n < 700) begin
            @(negedge clk);
            n++;
        end
        check("irq_tx_idle", 32'(irq), 32'd1);
        check("irq_after_frames", 32'(tx_exp.size()), 32'd0);
        check("irq_line_idle", 32'(uart_tx), 32'd1);
        read_check("b2b_level_end", A_LVL, 16'h0000);

        // Loopback
        bus_write(A_IEN, 16'h0001);
        loop_en = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_rx_empty", 32'(irq), 32'd0);
        tx_exp.push_back(32'hA5);
        rx_exp.push_back(32'hA5);
        bus_write(A_TX, 16'h00A5);
        n = 0;
        while (tx_exp.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("loop_tx_drained", 32'(tx_exp.size()), 32'd0);
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        read_check("loop_status", A_ST, 16'h0002);
        check("irq_rx_ready", 32'(irq), 32'd1);
        read_rx("loop_rxdata");
        read_check("loop_status_empty", A_ST, 16'h000A);
        read_check("rx_read_empty", A_RX, 16'h0000);
        check("irq_rx_drained", 32'(irq), 32'd0);
        bus_write(A_IEN, 16'h0000);

        // Driven RX frame
        rx_exp.push_back(32'h3C);
        send_rx(8'h3C, 1'b1, 1'b0, 1'b0);
        read_check("rx_level", A_LVL, 16'h0100);
        read_rx("rx_rxdata");

        // Framing error, then clear
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        read_check("frame_err_status", A_ST, 16'h004A);
        read_check("frame_err_level", A_LVL, 16'h0000);
        bus_write(A_CLR, 16'h0040);
        read_check("frame_err_clear", A_ST, 16'h000A);

        // Short glitch rejected
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_rx_led", 32'(rx_led), 32'd0);
        read_check("glitch_status", A_ST, 16'h000A);
        read_check("glitch_level", A_LVL, 16'h0000);

        // TX FIFO fill and overflow with a very slow tick
        bus_write(A_DIV, 16'hFFFF);
        for (int i = 0; i < 16; i++) bus_write(A_TX, 16'(i));
        read_check("fill_status", A_ST, 16'h0009);
        read_check("fill_level", A_LVL, 16'h0010);
        bus_write(A_TX, 16'h00EE);
        read_check("tx_ovf_status", A_ST, 16'h0089);
        bus_write(A_CLR, 16'h0080);
        read_check("tx_ovf_clear", A_ST, 16'h0009);

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1;
        check("async_rst_data_out", 32'(data_out), 32'd0);
        check("async_rst_uart_tx", 32'(uart_tx), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        read_check("post_rst_level", A_LVL, 16'h0000);
        read_check("post_rst_div", A_DIV, 16'd26);
        bus_write(A_DIV, 16'd0);

`ifdef UART_PARITY_EN
        // Odd parity, 0x07 has three ones so the correct bit is 0; send 1
        bus_write(A_CTRL, 16'h0003);
        read_check("ctrl_rdback", A_CTRL, 16'h0003);
        rx_exp.push_back(32'h07);
        send_rx(8'h07, 1'b1, 1'b1, 1'b1);
        read_check("par_err_status", A_ST, 16'h0102);
        read_rx("par_rxdata");
`else
        bus_write(A_CTRL, 16'h0003);
        read_check("ctrl_reads_zero", A_CTRL, 16'h0000);
        rx_exp.push_back(32'h07);
        send_rx(8'h07, 1'b1, 1'b0, 1'b0);
        read_check("no_par_status", A_ST, 16'h0002);
        read_rx("no_par_rxdata");
`endif

        check("rx_sb_empty", 32'(rx_exp.size()), 32'd0);
        check("tx_sb_empty", 32'(tx_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
